first_one_scanner: RTL and testbench

- Parametrised, sequential successor to the team's 4-bit first-one encoder.
- Accepts a WIDTH-bit vector over a valid/ready handshake, then emits the index of every set bit, one per cycle, over a second valid/ready handshake.
- Scan order is selectable per vector: LSB-first or MSB-first.
- Used wherever request/interrupt/flag vectors must be serialised into index streams.

---
 rtl/first_one_scanner.sv | 99 +++++++++
 tb/tb_first_one_scanner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/first_one_scanner.sv
// Serialises a WIDTH-bit vector into a stream of set-bit indices, one per cycle,
// in LSB-first or MSB-first order chosen per vector.
module first_one_scanner #(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_cnt,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic             r_dir;
    logic [IDX_W:0]   r_cnt;

    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic [WIDTH-1:0] w_clear;
    logic             w_accept;
    logic             w_beat;

    // Priority scans: the last assignment in each loop wins, giving the
    // lowest set bit for the descending loop and the highest for the ascending one.
    always_comb begin
        w_lo_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_work[i]) w_lo_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_work[i]) w_hi_idx = IDX_W'(i);
        end
    end

    // Outputs depend only on registered state (and rst_n/abort for the
    // handshake qualifiers); out_ready never reaches an output combinationally.
    assign out_idx   = r_dir ? w_hi_idx : w_lo_idx;
    assign out_none  = (r_work == '0);
    assign out_last  = ((r_work & (r_work - WIDTH'(1))) == '0);
    assign out_cnt   = r_cnt;
    assign out_valid = rst_n && (r_state == S_SCAN);
    assign in_ready  = rst_n && (r_state == S_IDLE) && !abort;

    assign w_clear  = WIDTH'(1) << out_idx;
    assign w_accept = in_valid && in_ready;
    assign w_beat   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SCAN;
                        r_work  <= in_vec;
                        r_dir   <= in_dir;
                        r_cnt   <= '0;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_work  <= '0;
                        r_cnt   <= '0;
                    end else if (w_beat) begin
                        r_work <= r_work & ~w_clear;
                        r_cnt  <= r_cnt + (IDX_W + 1)'(1);
                        if (out_last) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_first_one_scanner.sv
// Directed bench for first_one_scanner: a WIDTH=16 instance for the main
// scenarios and a WIDTH=5 instance for non-power-of-two width and mid-scan reset.
module tb_first_one_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=16 instance
    logic        a_rst_n, a_abort, a_in_valid, a_in_ready, a_in_dir;
    logic [15:0] a_in_vec;
    logic        a_out_valid, a_out_ready, a_out_last, a_out_none;
    logic [3:0]  a_out_idx;
    logic [4:0]  a_out_cnt;

    // WIDTH=5 instance
    logic        b_rst_n, b_abort, b_in_valid, b_in_ready, b_in_dir;
    logic [4:0]  b_in_vec;
    logic        b_out_valid, b_out_ready, b_out_last, b_out_none;
    logic [2:0]  b_out_idx;
    logic [3:0]  b_out_cnt;

    first_one_scanner #(.WIDTH(16)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .abort(a_abort),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec), .in_dir(a_in_dir),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_cnt(a_out_cnt), .out_last(a_out_last), .out_none(a_out_none)
    );

    first_one_scanner #(.WIDTH(5)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .abort(b_abort),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec), .in_dir(b_in_dir),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_cnt(b_out_cnt), .out_last(b_out_last), .out_none(b_out_none)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check one output beat of instance A in the current cycle, then advance.
    task automatic beat_a(input string tag, input int idx, input int cnt, input bit last, input bit none);
        #1;
        check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        check({tag, ".idx"},   32'(a_out_idx),   32'(idx));
        check({tag, ".cnt"},   32'(a_out_cnt),   32'(cnt));
        check({tag, ".last"},  32'(a_out_last),  32'(last));
        check({tag, ".none"},  32'(a_out_none),  32'(none));
        check({tag, ".in_rdy"}, 32'(a_in_ready), 32'd0);
        cyc();
    endtask

    task automatic beat_b(input string tag, input int idx, input int cnt, input bit last);
        #1;
        check({tag, ".valid"}, 32'(b_out_valid), 32'd1);
        check({tag, ".idx"},   32'(b_out_idx),   32'(idx));
        check({tag, ".cnt"},   32'(b_out_cnt),   32'(cnt));
        check({tag, ".last"},  32'(b_out_last),  32'(last));
        cyc();
    endtask

    task automatic idle_a(input string tag);
        #1;
        check({tag, ".valid"},  32'(a_out_valid), 32'd0);
        check({tag, ".in_rdy"}, 32'(a_in_ready),  32'd1);
    endtask

    initial begin
        a_rst_n = 1'b0; a_abort = 1'b0; a_in_valid = 1'b0; a_in_vec = '0; a_in_dir = 1'b0; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_vec = '0; b_in_dir = 1'b0; b_out_ready = 1'b0;

        // Reset
        cyc();
        cyc();
        check("rst.a_valid", 32'(a_out_valid), 32'd0);
        check("rst.a_in_rdy", 32'(a_in_ready), 32'd0);
        check("rst.b_in_rdy", 32'(b_in_ready), 32'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        cyc();
        idle_a("post_rst");

        // 0x8421 LSB-first
        a_in_valid = 1'b1; a_in_vec = 16'h8421; a_in_dir = 1'b0; a_out_ready = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        beat_a("lsb0", 0, 0, 0, 0);
        beat_a("lsb1", 5, 1, 0, 0);
        beat_a("lsb2", 10, 2, 0, 0);
        beat_a("lsb3", 15, 3, 1, 0);
        idle_a("lsb_end");

        // 0x8421 MSB-first
        a_in_valid = 1'b1; a_in_dir = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        beat_a("msb0", 15, 0, 0, 0);
        beat_a("msb1", 10, 1, 0, 0);
        beat_a("msb2", 5, 2, 0, 0);
        beat_a("msb3", 0, 3, 1, 0);
        idle_a("msb_end");

        // Zero vector
        a_in_valid = 1'b1; a_in_vec = 16'h0000; a_in_dir = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        beat_a("zero", 0, 0, 1, 1);
        idle_a("zero_end");

        // Backpressure on 0x0003
        a_in_valid = 1'b1; a_in_vec = 16'h0003; a_out_ready = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        beat_a("bp_hold0", 0, 0, 0, 0);
        beat_a("bp_hold1", 0, 0, 0, 0);
        beat_a("bp_hold2", 0, 0, 0, 0);
        a_out_ready = 1'b1;
        beat_a("bp0", 0, 0, 0, 0);
        beat_a("bp1", 1, 1, 1, 0);
        idle_a("bp_end");

        // Full vector MSB-first: 16 beats
        a_in_valid = 1'b1; a_in_vec = 16'hFFFF; a_in_dir = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) beat_a("full", 15 - i, i, (i == 15), 0);
        idle_a("full_end");

        // Abort mid-scan of 0xFFFF
        a_in_valid = 1'b1; a_in_vec = 16'hFFFF; a_in_dir = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        beat_a("ab0", 0, 0, 0, 0);
        a_abort = 1'b1; a_in_valid = 1'b1; a_in_vec = 16'h00F0;
        #1;
        check("ab1.valid", 32'(a_out_valid), 32'd1);
        check("ab1.idx", 32'(a_out_idx), 32'd1);
        check("ab1.in_rdy", 32'(a_in_ready), 32'd0);
        cyc();
        a_abort = 1'b0; a_in_valid = 1'b0;
        idle_a("ab_after");
        // abort in IDLE blocks acceptance
        a_abort = 1'b1; a_in_valid = 1'b1;
        #1;
        check("ab_idle.in_rdy", 32'(a_in_ready), 32'd0);
        cyc();
        a_abort = 1'b0; a_in_valid = 1'b0;
        idle_a("ab_idle_end");
        // counter and work restart cleanly after abort
        a_in_valid = 1'b1; a_in_vec = 16'h0020; a_in_dir = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        beat_a("ab_reload", 5, 0, 1, 0);
        idle_a("ab_reload_end");

        // in_valid held across the last beat: accepted one cycle later
        a_in_valid = 1'b1; a_in_vec = 16'h0002;
        cyc();
        a_in_vec = 16'h0400;
        beat_a("ovl0", 1, 0, 1, 0);
        #1;
        check("ovl_bubble.valid", 32'(a_out_valid), 32'd0);
        check("ovl_bubble.in_rdy", 32'(a_in_ready), 32'd1);
        cyc();
        a_in_valid = 1'b0;
        beat_a("ovl1", 10, 0, 1, 0);
        idle_a("ovl_end");

        // WIDTH=5: reset mid-scan of 5'b11111
        b_in_valid = 1'b1; b_in_vec = 5'b11111; b_in_dir = 1'b0; b_out_ready = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        beat_b("b5_0", 0, 0, 0);
        beat_b("b5_1", 1, 1, 0);
        b_rst_n = 1'b0;
        #1;
        check("b5_rst.valid", 32'(b_out_valid), 32'd0);
        check("b5_rst.in_rdy", 32'(b_in_ready), 32'd0);
        cyc();
        b_rst_n = 1'b1;
        #1;
        check("b5_post.valid", 32'(b_out_valid), 32'd0);
        check("b5_post.in_rdy", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1; b_in_vec = 5'b10000;
        cyc();
        b_in_valid = 1'b0;
        beat_b("b5_top", 4, 0, 1);
        #1;
        check("b5_top_end.valid", 32'(b_out_valid), 32'd0);
        // MSB-first on 5'b10110
        b_in_valid = 1'b1; b_in_vec = 5'b10110; b_in_dir = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        beat_b("b5_m0", 4, 0, 0);
        beat_b("b5_m1", 2, 1, 0);
        beat_b("b5_m2", 1, 2, 1);
        #1;
        check("b5_m_end.in_rdy", 32'(b_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
